// File: rtl/inst_fetch_bridge.sv
// Instruction-fetch bridge: turns PC-stage requests into single-outstanding bus reads
// and buffers returned instructions in a 2-entry queue toward decode.
module inst_fetch_bridge #(
    parameter int ADDR_W = 32,
    parameter int INST_W = 32
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic [ADDR_W-1:0] IF_pc,
    input  logic              Inst_Req_Vaild,
    input  logic              IF_delay_slot,
    input  logic              IF_flush,
    output logic              Inst_Req_Ack,
    output logic              inst_req,
    output logic [ADDR_W-1:0] inst_addr,
    input  logic              inst_addr_ok,
    input  logic              inst_data_ok,
    input  logic [INST_W-1:0] inst_rdata,
    input  logic              ID_allowin,
    output logic              IF_to_ID_valid,
    output logic [INST_W-1:0] IF_to_ID_inst,
    output logic [ADDR_W-1:0] IF_to_ID_pc,
    output logic              IF_to_ID_delay_slot,
    output logic              IF_to_ID_addr_err
);

    typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;

    typedef struct packed {
        logic [INST_W-1:0] inst;
        logic [ADDR_W-1:0] pc;
        logic              tag;
        logic              err;
    } entry_t;

    state_t      state, state_nxt;
    logic [ADDR_W-1:0] addr_q;
    logic        tag_q;
    logic        discard_q;
    logic        mis_ack_q;
    logic [1:0]  count_q, count_nxt;
    entry_t      ent_q [2];
    entry_t      ent_nxt [2];

    logic        pop, pending, credit, data_done, start, aligned;
    logic        push_data, push_mis;
    logic [2:0]  occ;
    entry_t      data_ent, mis_ent;

    assign pop       = (count_q != 2'd0) && ID_allowin;
    assign pending   = (state != IDLE);
    // Credit counts the in-flight read as an occupied slot and a pop this cycle as a freed one.
    assign occ       = {1'b0, count_q} + {2'b0, pending} - {2'b0, pop};
    assign credit    = (occ < 3'd2);
    assign data_done = (state == WAIT) && inst_data_ok;
    assign aligned   = (IF_pc[1:0] == 2'b00);
    // The ack cycle of a misaligned fetch still shows the old PC, so no start there.
    assign start     = ((state == IDLE) || data_done) && Inst_Req_Vaild && credit
                       && !IF_flush && !mis_ack_q;
    assign push_data = data_done && !discard_q && !IF_flush;
    assign push_mis  = start && !aligned;

    assign data_ent  = '{inst_rdata, addr_q, tag_q, 1'b0};
    assign mis_ent   = '{{INST_W{1'b0}}, IF_pc, IF_delay_slot, 1'b1};

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start && aligned) state_nxt = REQ;
            REQ:     if (inst_addr_ok) state_nxt = WAIT;
            WAIT:    if (inst_data_ok) state_nxt = (start && aligned) ? REQ : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Queue next-state: pop first, then append data return before a misaligned entry.
    always_comb begin
        ent_nxt[0] = pop ? ent_q[1] : ent_q[0];
        ent_nxt[1] = ent_q[1];
        count_nxt  = count_q - {1'b0, pop};
        if (push_data) begin
            if (count_nxt == 2'd0) ent_nxt[0] = data_ent;
            else                   ent_nxt[1] = data_ent;
            count_nxt = count_nxt + 2'd1;
        end
        if (push_mis) begin
            if (count_nxt == 2'd0) ent_nxt[0] = mis_ent;
            else                   ent_nxt[1] = mis_ent;
            count_nxt = count_nxt + 2'd1;
        end
        if (IF_flush) count_nxt = 2'd0;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state     <= IDLE;
            count_q   <= 2'd0;
            discard_q <= 1'b0;
            mis_ack_q <= 1'b0;
            addr_q    <= '0;
        end else begin
            state     <= state_nxt;
            count_q   <= count_nxt;
            mis_ack_q <= push_mis;
            if (data_done)                discard_q <= 1'b0;
            else if (IF_flush && pending) discard_q <= 1'b1;
            if (start && aligned)         addr_q    <= IF_pc;
        end
    end

    always_ff @(posedge clk) begin
        ent_q[0] <= ent_nxt[0];
        ent_q[1] <= ent_nxt[1];
        if (start && aligned) tag_q <= IF_delay_slot;
    end

    assign inst_req            = (state == REQ);
    assign inst_addr           = addr_q;
    assign Inst_Req_Ack        = ((state == REQ) && inst_addr_ok) || mis_ack_q;
    assign IF_to_ID_valid      = (count_q != 2'd0);
    assign IF_to_ID_inst       = IF_to_ID_valid ? ent_q[0].inst : '0;
    assign IF_to_ID_pc         = IF_to_ID_valid ? ent_q[0].pc   : '0;
    assign IF_to_ID_delay_slot = IF_to_ID_valid && ent_q[0].tag;
    assign IF_to_ID_addr_err   = IF_to_ID_valid && ent_q[0].err;

endmodule

// File: tb/tb_inst_fetch_bridge.sv
// Bench for inst_fetch_bridge: directed scenarios with literal expectations plus random
// traffic, all checked every cycle against a queue-based reference model.
module tb_inst_fetch_bridge;

    logic        clk = 1'b0;
    logic        resetn;
    logic [31:0] IF_pc;
    logic        Inst_Req_Vaild, IF_delay_slot, IF_flush;
    logic        Inst_Req_Ack, inst_req;
    logic [31:0] inst_addr;
    logic        inst_addr_ok, inst_data_ok;
    logic [31:0] inst_rdata;
    logic        ID_allowin;
    logic        IF_to_ID_valid;
    logic [31:0] IF_to_ID_inst, IF_to_ID_pc;
    logic        IF_to_ID_delay_slot, IF_to_ID_addr_err;

    inst_fetch_bridge #(.ADDR_W(32), .INST_W(32)) dut (
        .clk(clk), .resetn(resetn), .IF_pc(IF_pc), .Inst_Req_Vaild(Inst_Req_Vaild),
        .IF_delay_slot(IF_delay_slot), .IF_flush(IF_flush), .Inst_Req_Ack(Inst_Req_Ack),
        .inst_req(inst_req), .inst_addr(inst_addr), .inst_addr_ok(inst_addr_ok),
        .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata), .ID_allowin(ID_allowin),
        .IF_to_ID_valid(IF_to_ID_valid), .IF_to_ID_inst(IF_to_ID_inst),
        .IF_to_ID_pc(IF_to_ID_pc), .IF_to_ID_delay_slot(IF_to_ID_delay_slot),
        .IF_to_ID_addr_err(IF_to_ID_addr_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
        logic        tag;
        logic        err;
    } ent_t;

    // Reference model: the decode queue as a plain queue plus the one outstanding read.
    ent_t        mq[$];
    bit          m_addr_ph, m_data_ph, m_discard, m_mis;
    logic [31:0] m_addr;
    logic        m_tag;

    logic        obs_ack, obs_req, obs_valid, obs_tag, obs_err, prev_ack;
    logic [31:0] obs_addr, obs_inst, obs_pc;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        m_addr_ph = 0; m_data_ph = 0; m_discard = 0; m_mis = 0;
        m_addr = 32'h0; m_tag = 1'b0; prev_ack = 1'b0;
    endtask

    task automatic model_update();
        bit pop, inflight, data_back, may_start, aligned;
        int room;
        pop       = (mq.size() > 0) && ID_allowin;
        inflight  = m_addr_ph || m_data_ph;
        room      = 2 - mq.size() + int'(pop) - int'(inflight);
        data_back = m_data_ph && inst_data_ok;
        may_start = (!inflight || data_back) && Inst_Req_Vaild && (room > 0) && !IF_flush && !m_mis;
        aligned   = (IF_pc[1:0] == 2'b00);
        if (pop) void'(mq.pop_front());
        if (data_back && !m_discard && !IF_flush) mq.push_back({inst_rdata, m_addr, m_tag, 1'b0});
        if (may_start && !aligned) mq.push_back({32'h0, IF_pc, IF_delay_slot, 1'b1});
        if (IF_flush) mq.delete();
        if (data_back)                  m_discard = 0;
        else if (IF_flush && inflight)  m_discard = 1;
        if (m_addr_ph && inst_addr_ok) begin m_addr_ph = 0; m_data_ph = 1; end
        else if (data_back) m_data_ph = 0;
        if (may_start && aligned) begin m_addr_ph = 1; m_addr = IF_pc; m_tag = IF_delay_slot; end
        m_mis = may_start && !aligned;
    endtask

    // One clock: compare mid-cycle against the model, then advance the model at the edge.
    task automatic cycle();
        ent_t head;
        #3;
        if (!resetn) model_reset();
        head = (mq.size() > 0) ? mq[0] : '0;
        obs_ack = Inst_Req_Ack; obs_req = inst_req; obs_addr = inst_addr;
        obs_valid = IF_to_ID_valid; obs_inst = IF_to_ID_inst; obs_pc = IF_to_ID_pc;
        obs_tag = IF_to_ID_delay_slot; obs_err = IF_to_ID_addr_err;
        chk("ack", obs_ack, (m_addr_ph && inst_addr_ok) || m_mis);
        chk("inst_req", obs_req, m_addr_ph);
        chk("inst_addr", obs_addr, m_addr);
        chk("id_valid", obs_valid, mq.size() > 0);
        chk("id_inst", obs_inst, head.inst);
        chk("id_pc", obs_pc, head.pc);
        chk("id_tag", obs_tag, head.tag);
        chk("id_addr_err", obs_err, head.err);
        chk("ack_gap", obs_ack & prev_ack, 1'b0);
        prev_ack = obs_ack;
        @(posedge clk);
        if (resetn) model_update();
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] pc, input logic fl, input logic aok,
                         input logic dok, input logic [31:0] rd, input logic alw);
        Inst_Req_Vaild = v; IF_pc = pc; IF_delay_slot = pc[3]; IF_flush = fl;
        inst_addr_ok = aok; inst_data_ok = dok; inst_rdata = rd; ID_allowin = alw;
    endtask

    initial begin
        model_reset();
        resetn = 1'b0;
        drive(0, 0, 0, 0, 0, 0, 0);
        cycle();
        chk("rst_req", obs_req, 1'b0); chk("rst_valid", obs_valid, 1'b0);
        chk("rst_ack", obs_ack, 1'b0); chk("rst_addr", obs_addr, 32'h0);
        cycle();
        resetn = 1'b1;

        // Single aligned fetch
        drive(1, 32'h0, 0, 0, 0, 0, 0); cycle();
        drive(0, 32'h0, 0, 1, 0, 0, 0); cycle();
        chk("single_ack", obs_ack, 1'b1); chk("single_req", obs_req, 1'b1);
        chk("single_addr", obs_addr, 32'h0);
        drive(0, 32'h0, 0, 0, 0, 0, 0); cycle();
        drive(0, 32'h0, 0, 0, 1, 32'h2408_0001, 0); cycle();
        drive(0, 32'h0, 0, 0, 0, 0, 1); cycle();
        chk("single_valid", obs_valid, 1'b1); chk("single_inst", obs_inst, 32'h2408_0001);
        chk("single_pc", obs_pc, 32'h0);
        drive(0, 32'h0, 0, 0, 0, 0, 0); cycle();
        chk("single_drained", obs_valid, 1'b0);

        // Misaligned PC
        drive(1, 32'h0000_0102, 0, 0, 0, 0, 0); cycle();
        chk("mis_no_req", obs_req, 1'b0);
        drive(0, 32'h0000_0102, 0, 0, 0, 0, 1); cycle();
        chk("mis_ack", obs_ack, 1'b1); chk("mis_req", obs_req, 1'b0);
        chk("mis_valid", obs_valid, 1'b1); chk("mis_err", obs_err, 1'b1);
        chk("mis_inst", obs_inst, 32'h0); chk("mis_pc", obs_pc, 32'h0000_0102);
        drive(0, 32'h0, 0, 0, 0, 0, 0); cycle();
        chk("mis_ack_once", obs_ack, 1'b0);

        // Flush while waiting for data
        drive(1, 32'h100, 0, 0, 0, 0, 0); cycle();
        drive(0, 32'h100, 0, 1, 0, 0, 0); cycle();
        chk("fw_ack", obs_ack, 1'b1);
        drive(0, 32'h100, 1, 0, 0, 0, 0); cycle();
        drive(0, 32'h100, 0, 0, 1, 32'hDEAD_BEEF, 0); cycle();
        drive(0, 32'h0, 0, 0, 0, 0, 0); cycle();
        chk("fw_dropped", obs_valid, 1'b0);
        drive(1, 32'h380, 0, 0, 0, 0, 0); cycle();
        drive(0, 32'h380, 0, 1, 0, 0, 0); cycle();
        drive(0, 32'h380, 0, 0, 1, 32'h1234_5678, 0); cycle();
        drive(0, 32'h0, 0, 0, 0, 0, 1); cycle();
        chk("fw_next_pc", obs_pc, 32'h380); chk("fw_next_inst", obs_inst, 32'h1234_5678);

        // Flush in REQ with addr_ok held off
        drive(1, 32'h200, 0, 0, 0, 0, 0); cycle();
        drive(0, 32'h200, 1, 0, 0, 0, 0); cycle();
        chk("fr_req0", obs_req, 1'b1); chk("fr_addr0", obs_addr, 32'h200);
        for (int i = 0; i < 2; i++) begin
            drive(0, 32'h0, 0, 0, 0, 0, 0); cycle();
            chk("fr_req_held", obs_req, 1'b1); chk("fr_addr_held", obs_addr, 32'h200);
        end
        drive(0, 32'h0, 0, 1, 0, 0, 0); cycle();
        chk("fr_ack", obs_ack, 1'b1);
        drive(0, 32'h0, 0, 0, 1, 32'hCAFE_0001, 0); cycle();
        drive(0, 32'h0, 0, 0, 0, 0, 1); cycle();
        chk("fr_dropped", obs_valid, 1'b0);

        // Backpressure: two entries fill the queue and block a third request
        drive(1, 32'h0, 0, 0, 0, 0, 0); cycle();
        drive(1, 32'h0, 0, 1, 0, 0, 0); cycle();
        drive(1, 32'h4, 0, 0, 1, 32'hA000_0000, 0); cycle();
        drive(1, 32'h4, 0, 1, 0, 0, 0); cycle();
        chk("bp_addr4", obs_addr, 32'h4);
        drive(1, 32'h8, 0, 0, 1, 32'hA000_0004, 0); cycle();
        for (int i = 0; i < 3; i++) begin
            drive(1, 32'h8, 0, 0, 0, 0, 0); cycle();
            chk("bp_no_req", obs_req, 1'b0); chk("bp_head", obs_pc, 32'h0);
        end
        drive(1, 32'h8, 0, 0, 0, 0, 1); cycle();
        drive(0, 32'h8, 0, 0, 0, 0, 0); cycle();
        chk("bp_req8", obs_req, 1'b1); chk("bp_addr8", obs_addr, 32'h8);
        chk("bp_head4", obs_pc, 32'h4);
        drive(0, 32'h0, 0, 1, 0, 0, 0); cycle();
        drive(0, 32'h0, 0, 0, 1, 32'hA000_0008, 1); cycle();
        for (int i = 0; i < 3; i++) begin drive(0, 32'h0, 0, 0, 0, 0, 1); cycle(); end
        chk("bp_drained", obs_valid, 1'b0);

        // Reset while waiting for data
        drive(1, 32'h40, 0, 0, 0, 0, 0); cycle();
        drive(0, 32'h40, 0, 1, 0, 0, 0); cycle();
        resetn = 1'b0;
        drive(0, 32'h0, 0, 0, 0, 0, 0); cycle();
        chk("rw_req", obs_req, 1'b0); chk("rw_valid", obs_valid, 1'b0);
        chk("rw_addr", obs_addr, 32'h0);
        resetn = 1'b1;
        drive(0, 32'h0, 0, 0, 1, 32'h5555_AAAA, 0); cycle();
        drive(0, 32'h0, 0, 0, 0, 0, 0); cycle();
        chk("rw_ignored", obs_valid, 1'b0);

        // Random traffic
        for (int n = 0; n < 4000; n++) begin
            logic [31:0] pc;
            pc = $urandom & 32'h0000_0FFF;
            if ($urandom_range(0, 5) != 0) pc[1:0] = 2'b00;
            drive($urandom_range(0, 3) != 0, pc, $urandom_range(0, 15) == 0,
                  $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, $urandom,
                  $urandom_range(0, 2) != 0);
            IF_delay_slot = $urandom_range(0, 1) == 1;
            cycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
